// File: rtl/sb_sh_scheduler_if.sv
// Word-wide data-memory port used by sb_sh_scheduler; master drives the request, slave answers.
interface sb_sh_scheduler_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/sb_sh_scheduler.sv
// Read-modify-write sequencer turning MIPS SB/SH into a word read, byte-lane merge and word write.
// Optional build macro SB_SH_ALIGN_CHECK_EN rejects SH with eff_addr[0]=1 through a one-cycle addr_err pulse.
module sb_sh_scheduler #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_instr_valid,
    input  logic [5:0]        i_op,
    input  logic [ADDR_W-1:0] i_eff_addr,
    input  logic [31:0]       i_store_data,
    sb_sh_scheduler_if.master mem,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_addr_err
);
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        r_state;
    logic              r_is_half;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_word_addr;
    logic [15:0]       r_data;
    logic [31:0]       r_wdata;

    logic              w_start;
    logic              w_idle;
    logic              w_misalign;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_start  = i_instr_valid && (i_op == OP_SB || i_op == OP_SH);
    assign w_idle   = (r_state == S_IDLE);
    assign w_unused = ^i_store_data[31:16];

`ifdef SB_SH_ALIGN_CHECK_EN
    assign w_misalign = w_start && (i_op == OP_SH) && i_eff_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_half   <= 1'b0;
            r_lane      <= 2'b00;
            r_word_addr <= '0;
            r_data      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_misalign) begin
                            r_state <= S_ERR;
                        end else begin
                            r_is_half   <= (i_op == OP_SH);
                            r_lane      <= i_eff_addr[1:0];
                            r_word_addr <= {i_eff_addr[ADDR_W-1:2], 2'b00};
                            r_data      <= i_store_data[15:0];
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // Merge at read capture so the write data is a stable register.
                    if (!mem.mem_waitrequest) begin
                        r_wdata <= w_merged;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!mem.mem_waitrequest) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE, S_ERR: r_state <= S_IDLE;
                default:       r_state <= S_IDLE;
            endcase
        end
    end

    // SH lane uses bit 1 only, so an unchecked odd SH address lands on the aligned half.
    always_comb begin
        w_merged = mem.mem_readdata;
        if (r_is_half) begin
            if (r_lane[1]) w_merged[31:16] = r_data[15:0];
            else           w_merged[15:0]  = r_data[15:0];
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end
    end

    assign o_busy     = (r_state == S_READ) || (r_state == S_WRITE);
    assign o_stall    = (w_idle && w_start) || o_busy;
    assign o_done     = (r_state == S_DONE);
    assign o_addr_err = w_idle && w_misalign;

    assign mem.mem_read      = (r_state == S_READ);
    assign mem.mem_write     = (r_state == S_WRITE);
    assign mem.mem_address   = o_busy ? r_word_addr : '0;
    assign mem.mem_writedata = (r_state == S_WRITE) ? r_wdata : '0;
endmodule

// File: tb/tb_sb_sh_scheduler.sv
// Directed bench for sb_sh_scheduler: scoreboard of expected write words, memory model with waitrequest.
module tb_sb_sh_scheduler;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_LW = 6'b100011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] eff_addr = '0;
    logic [31:0] store_data = '0;
    logic        stall, busy, done, addr_err;

    int total = 0;
    int bad = 0;
    logic [63:0] sb_q[$];

    sb_sh_scheduler_if #(.ADDR_W(32)) mif ();

    sb_sh_scheduler #(.ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_instr_valid (instr_valid),
        .i_op          (op),
        .i_eff_addr    (eff_addr),
        .i_store_data  (store_data),
        .mem           (mif.master),
        .o_stall       (stall),
        .o_busy        (busy),
        .o_done        (done),
        .o_addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic half, input logic [1:0] a,
                                              input logic [31:0] d, input logic [31:0] rd);
        logic [31:0] mask;
        int          sh;
        if (half) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 8 * int'(a);
            mask = 32'h0000_00FF << sh;
        end
        return (rd & ~mask) | ((d << sh) & mask);
    endfunction

    // Issues one store, answers the memory with rd_word and the given wait counts, checks timing and data.
    task automatic run_store(input string tag, input logic [5:0] t_op, input logic [31:0] t_addr,
                             input logic [31:0] t_data, input logic [31:0] t_rd,
                             input int rwait, input int wwait, input logic [31:0] t_exp);
        int   stalls = 0;
        int   nrd = 0;
        int   nwr = 0;
        int   rw = rwait;
        int   ww = wwait;
        bit   fin = 0;
        logic [31:0] waddr;
        logic [63:0] item;
        waddr = {t_addr[31:2], 2'b00};
        sb_q.push_back({waddr, t_exp});
        mif.mem_readdata = t_rd;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) begin
                instr_valid = 1'b1; op = t_op; eff_addr = t_addr; store_data = t_data;
            end else begin
                instr_valid = 1'b1; op = 6'b000000; eff_addr = $urandom; store_data = $urandom;
            end
            #1;
            mif.mem_waitrequest = 1'b0;
            if (mif.mem_read) begin
                nrd++;
                if (rw > 0) begin mif.mem_waitrequest = 1'b1; rw--; end
            end
            if (mif.mem_write) begin
                nwr++;
                if (ww > 0) begin mif.mem_waitrequest = 1'b1; ww--; end
            end
            #1;
            if (c == 0) chk({tag, " start_addr_err"}, {31'd0, addr_err}, 32'd0);
            if (stall) stalls++;
            if (mif.mem_read || mif.mem_write) begin
                chk({tag, " addr"}, mif.mem_address, waddr);
                chk({tag, " rw_excl"}, {31'd0, mif.mem_read && mif.mem_write}, 32'd0);
            end
            if (mif.mem_write && !mif.mem_waitrequest) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " unexpected_write"}, 32'd1, 32'd0);
                end else begin
                    item = sb_q.pop_front();
                    chk({tag, " wdata"}, mif.mem_writedata, item[31:0]);
                    chk({tag, " waddr"}, mif.mem_address, item[63:32]);
                end
            end
            if (done) begin
                fin = 1;
                chk({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
            end
        end
        mif.mem_waitrequest = 1'b0;
        chk({tag, " done_seen"}, {31'd0, fin}, 32'd1);
        chk({tag, " stalls"}, stalls, 3 + rwait + wwait);
        chk({tag, " read_cycles"}, nrd, 1 + rwait);
        chk({tag, " write_cycles"}, nwr, 1 + wwait);
        chk({tag, " queue_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        logic        half;
        logic [31:0] ra, rd, dd;
        int          rwt, wwt;

        mif.mem_waitrequest = 1'b0;
        mif.mem_readdata    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {26'd0, stall, busy, done, addr_err, mif.mem_read, mif.mem_write}, 32'd0);
        chk("reset_addr", mif.mem_address, 32'd0);
        chk("reset_wdata", mif.mem_writedata, 32'd0);
        reset = 1'b0;

        // Test-plan stores, back to back
        run_store("sb_1002", OP_SB, 32'h1002, 32'h0000_00AB, 32'h1122_3344, 0, 0, 32'h11AB_3344);
        run_store("sh_1002", OP_SH, 32'h1002, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 32'hBEEF_3344);
        run_store("sh_1000", OP_SH, 32'h1000, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 32'h1122_BEEF);
        run_store("sb_wait", OP_SB, 32'h2003, 32'h0000_0011, 32'hCAFE_F00D, 2, 1, 32'h11FE_F00D);

        // Non-store opcode
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr_valid = 1'b1; op = OP_LW; eff_addr = 32'h1000; store_data = 32'h1234_5678;
            #1;
            chk("lw_quiet", {28'd0, stall, busy, mif.mem_read, mif.mem_write}, 32'd0);
        end

        // Odd SH address
`ifdef SB_SH_ALIGN_CHECK_EN
        @(negedge clk);
        instr_valid = 1'b1; op = OP_SH; eff_addr = 32'h1001; store_data = 32'h0000_BEEF;
        #1;
        chk("align_err_cycle", {29'd0, addr_err, stall, mif.mem_read}, 32'd6);
        @(negedge clk);
        #1;
        chk("align_next_cycle", {27'd0, addr_err, stall, mif.mem_read, mif.mem_write, done}, 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("align_idle", {28'd0, stall, busy, mif.mem_read, done}, 32'd0);
`else
        run_store("sh_1001", OP_SH, 32'h1001, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 32'h1122_BEEF);
`endif

        // Reset while a write is held by waitrequest
        @(negedge clk);
        instr_valid = 1'b1; op = OP_SB; eff_addr = 32'h3001; store_data = 32'h0000_0055;
        mif.mem_readdata = 32'h0;
        @(negedge clk);
        op = 6'b000000;
        #1;
        chk("rst_in_read", {31'd0, mif.mem_read}, 32'd1);
        @(negedge clk);
        mif.mem_waitrequest = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_in_write", {31'd0, mif.mem_write}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mif.mem_waitrequest = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("rst_after", {29'd0, mif.mem_write, busy, done}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_no_done", {30'd0, done, mif.mem_read}, 32'd0);
        run_store("sb_after_rst", OP_SB, 32'h3001, 32'h0000_0055, 32'hA0A1_A2A3, 0, 0, 32'hA0A1_55A3);

        // Randomised stores against the reference merge
        for (int i = 0; i < 6; i++) begin
            half = 1'($urandom_range(0, 1));
            ra   = $urandom;
`ifdef SB_SH_ALIGN_CHECK_EN
            if (half) ra[0] = 1'b0;
`endif
            rd  = $urandom;
            dd  = $urandom;
            rwt = $urandom_range(0, 2);
            wwt = $urandom_range(0, 2);
            run_store("rand", half ? OP_SH : OP_SB, ra, dd, rd, rwt, wwt,
                      ref_merge(half, ra[1:0], dd, rd));
        end

        @(negedge clk);
        instr_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
